// File: rtl/fpnew_issue_rob_if.sv
// Core <-> ROB <-> FPU handshake bundle for fpnew_issue_rob.
// Signal suffixes (_i/_o) are from the reorder buffer's point of view.
interface fpnew_issue_rob_if #(
  parameter int unsigned Width      = 64,
  parameter int unsigned CtrlWidth  = 16,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned RdWidth    = 5
);
  localparam int unsigned TagWidth = $clog2(NumEntries);

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [3*Width-1:0]     req_operands_i;
  logic [CtrlWidth-1:0]   req_ctrl_i;
  logic [RdWidth-1:0]     req_rd_i;
  logic                   fpu_valid_o;
  logic                   fpu_ready_i;
  logic [3*Width-1:0]     fpu_operands_o;
  logic [CtrlWidth-1:0]   fpu_ctrl_o;
  logic [TagWidth-1:0]    fpu_tag_o;
  logic                   fpu_flush_o;
  logic                   fpu_rsp_valid_i;
  logic                   fpu_rsp_ready_o;
  logic [Width-1:0]       fpu_result_i;
  logic [4:0]             fpu_status_i;
  logic [TagWidth-1:0]    fpu_tag_i;
  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [Width-1:0]       wb_result_o;
  logic [4:0]             wb_status_o;
  logic [RdWidth-1:0]     wb_rd_o;
  logic                   flush_i;
  logic                   busy_o;
  logic                   err_o;

  modport slave (
    input  req_valid_i, req_operands_i, req_ctrl_i, req_rd_i, fpu_ready_i,
           fpu_rsp_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, wb_ready_i, flush_i,
    output req_ready_o, fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
           fpu_rsp_ready_o, wb_valid_o, wb_result_o, wb_status_o, wb_rd_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_operands_i, req_ctrl_i, req_rd_i, fpu_ready_i,
           fpu_rsp_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, wb_ready_i, flush_i,
    input  req_ready_o, fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
           fpu_rsp_ready_o, wb_valid_o, wb_result_o, wb_status_o, wb_rd_o, busy_o, err_o
  );
endinterface

// File: rtl/fpnew_issue_rob.sv
// Tags FP ops into the FPU and retires out-of-order responses in program order.
// Define FPNEW_ISSUE_ROB_BYPASS_EN for zero-latency write-back of in-order responses.
module fpnew_issue_rob #(
  parameter int unsigned Width      = 64,
  parameter int unsigned CtrlWidth  = 16,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned RdWidth    = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fpnew_issue_rob_if.slave bus
);
  localparam int unsigned TagWidth = $clog2(NumEntries);
  localparam logic [TagWidth:0] FullCnt = (TagWidth+1)'(NumEntries);

  typedef enum logic [1:0] {StFree, StIssued, StDone} ent_state_e;

  ent_state_e          state_q  [NumEntries];
  ent_state_e          state_d  [NumEntries];
  logic [RdWidth-1:0]  rd_q     [NumEntries];
  logic [RdWidth-1:0]  rd_d     [NumEntries];
  logic [Width-1:0]    result_q [NumEntries];
  logic [Width-1:0]    result_d [NumEntries];
  logic [4:0]          status_q [NumEntries];
  logic [4:0]          status_d [NumEntries];
  logic [TagWidth-1:0] head_q, head_d, tail_q, tail_d;
  logic [TagWidth:0]   count_q, count_d;
  logic                err_q, err_d;

  logic full, req_ready, alloc, rsp_hit, bypass, wb_valid, retire;
  logic [Width-1:0]   wb_result;
  logic [4:0]         wb_status;
  logic [RdWidth-1:0] wb_rd;

  // Issue path is purely combinational: a core request is only taken when the FPU takes it.
  assign full      = (count_q == FullCnt);
  assign req_ready = bus.fpu_ready_i & ~full & ~bus.flush_i;
  assign alloc     = bus.req_valid_i & req_ready;

  assign bus.req_ready_o     = req_ready;
  assign bus.fpu_valid_o     = bus.req_valid_i & ~full & ~bus.flush_i;
  assign bus.fpu_operands_o  = bus.req_operands_i;
  assign bus.fpu_ctrl_o      = CtrlWidth'(bus.req_ctrl_i);
  assign bus.fpu_tag_o       = tail_q;
  assign bus.fpu_flush_o     = bus.flush_i;
  assign bus.fpu_rsp_ready_o = 1'b1;

  assign rsp_hit = bus.fpu_rsp_valid_i & ~bus.flush_i & (state_q[bus.fpu_tag_i] == StIssued);

`ifdef FPNEW_ISSUE_ROB_BYPASS_EN
  assign bypass = rsp_hit & (bus.fpu_tag_i == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign wb_valid = ~bus.flush_i & ((state_q[head_q] == StDone) | bypass);
  assign retire   = wb_valid & bus.wb_ready_i;

  // Data outputs read as zero whenever nothing is being presented.
  always_comb begin
    wb_result = '0;
    wb_status = '0;
    wb_rd     = '0;
    if (wb_valid) begin
      wb_rd     = rd_q[head_q];
      wb_result = bypass ? bus.fpu_result_i : result_q[head_q];
      wb_status = bypass ? bus.fpu_status_i : status_q[head_q];
    end
  end

  assign bus.wb_valid_o  = wb_valid;
  assign bus.wb_result_o = wb_result;
  assign bus.wb_status_o = wb_status;
  assign bus.wb_rd_o     = wb_rd;
  assign bus.busy_o      = (count_q != '0);
  assign bus.err_o       = err_q;

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    result_d = result_q;
    status_d = status_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = err_q;
    if (bus.flush_i) begin
      for (int i = 0; i < NumEntries; i++) state_d[i] = StFree;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rsp_hit) begin
        state_d[bus.fpu_tag_i]  = StDone;
        result_d[bus.fpu_tag_i] = bus.fpu_result_i;
        status_d[bus.fpu_tag_i] = bus.fpu_status_i;
      end else if (bus.fpu_rsp_valid_i) begin
        err_d = 1'b1;
      end
      // Retire after the response update so a bypassed head goes straight to FREE.
      if (retire) begin
        state_d[head_q] = StFree;
        head_d          = head_q + TagWidth'(1);
      end
      if (alloc) begin
        state_d[tail_q] = StIssued;
        rd_d[tail_q]    = bus.req_rd_i;
        tail_d          = tail_q + TagWidth'(1);
      end
      count_d = count_q + (TagWidth+1)'(alloc) - (TagWidth+1)'(retire);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumEntries; i++) state_q[i] <= StFree;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is only ever read behind a DONE state, so it needs no reset.
  always_ff @(posedge clk_i) begin
    rd_q     <= rd_d;
    result_q <= result_d;
    status_q <= status_d;
  end

endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Scoreboard bench for fpnew_issue_rob: write-backs must match issue order.
// Works with or without FPNEW_ISSUE_ROB_BYPASS_EN defined.
module tb_fpnew_issue_rob;
`ifdef FPNEW_ISSUE_ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] res;
    logic [4:0]  sts;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   tail_m = 0;
  exp_t sb[$];
  logic [63:0] exp_res [4];
  logic [4:0]  exp_sts [4];

  fpnew_issue_rob_if #(.Width(64), .CtrlWidth(16), .NumEntries(4), .RdWidth(5)) bus ();

  fpnew_issue_rob #(.Width(64), .CtrlWidth(16), .NumEntries(4), .RdWidth(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted write-back must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid_o && bus.wb_ready_i) begin
      check("wb_sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(bus.wb_rd_o), 64'(e.rd));
        check("wb_result", bus.wb_result_o, e.res);
        check("wb_status", 64'(bus.wb_status_o), 64'(e.sts));
      end
    end
  end

  task automatic issue(input logic [4:0] rd, input logic [63:0] res, input logic [4:0] sts,
                       input bit track);
    exp_t e;
    bus.req_valid_i    = 1'b1;
    bus.fpu_ready_i    = 1'b1;
    bus.req_rd_i       = rd;
    bus.req_operands_i = {3{res}};
    bus.req_ctrl_i     = 16'hA5A5 ^ {11'd0, rd};
    @(negedge clk);
    check("iss_ready", 64'(bus.req_ready_o), 64'd1);
    check("iss_tag", 64'(bus.fpu_tag_o), 64'(tail_m));
    check("iss_ctrl", 64'(bus.fpu_ctrl_o), 64'(16'hA5A5 ^ {11'd0, rd}));
    check("iss_opnd", bus.fpu_operands_o[127:64], res);
    exp_res[tail_m] = res;
    exp_sts[tail_m] = sts;
    e.rd = rd; e.res = res; e.sts = sts;
    if (track) sb.push_back(e);
    tail_m = (tail_m + 1) % 4;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [1:0] tag);
    bus.fpu_rsp_valid_i = 1'b1;
    bus.fpu_tag_i       = tag;
    bus.fpu_result_i    = exp_res[tag];
    bus.fpu_status_i    = exp_sts[tag];
    step();
    bus.fpu_rsp_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e5;
    bus.req_valid_i = 0; bus.req_operands_i = '0; bus.req_ctrl_i = '0; bus.req_rd_i = '0;
    bus.fpu_ready_i = 1; bus.fpu_rsp_valid_i = 0; bus.fpu_result_i = '0;
    bus.fpu_status_i = '0; bus.fpu_tag_i = '0; bus.wb_ready_i = 1; bus.flush_i = 0;
    for (int i = 0; i < 4; i++) begin exp_res[i] = '0; exp_sts[i] = '0; end

    // Reset state
    #12;
    check("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_wb_result", bus.wb_result_o, 64'd0);
    check("rst_wb_rd", 64'(bus.wb_rd_o), 64'd0);
    check("rst_req_ready_hi", 64'(bus.req_ready_o), 64'd1);
    bus.fpu_ready_i = 0;
    #1 check("rst_req_ready_lo", 64'(bus.req_ready_o), 64'd0);
    step();
    rst_n = 1'b1;

    // Single op and response latency
    issue(5'd3, 64'h4000_0000_0000_0000, 5'd0, 1'b1);
    bus.fpu_rsp_valid_i = 1'b1; bus.fpu_tag_i = 2'd0;
    bus.fpu_result_i = 64'h4000_0000_0000_0000; bus.fpu_status_i = 5'd0;
    @(negedge clk);
    check("t1_wb_same_cycle", 64'(bus.wb_valid_o), 64'(BYP));
    step();
    bus.fpu_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("t1_wb_next_cycle", 64'(bus.wb_valid_o), 64'(!BYP));
    step();
    @(negedge clk);
    check("t1_busy_clear", 64'(bus.busy_o), 64'd0);
    step();

    // FPU back-pressure holds the core, out-of-order responses retire in order
    bus.req_valid_i = 1'b1; bus.fpu_ready_i = 1'b0;
    @(negedge clk);
    check("nordy_req_ready", 64'(bus.req_ready_o), 64'd0);
    check("nordy_fpu_valid", 64'(bus.fpu_valid_o), 64'd1);
    step();
    issue(5'd1, 64'h3FF0_0000_0000_0001, 5'h01, 1'b1);
    issue(5'd2, 64'hC008_0000_0000_0002, 5'h04, 1'b1);
    issue(5'd3, 64'h7FF0_0000_0000_0000, 5'h10, 1'b1);
    respond(2'd3);
    respond(2'd1);
    respond(2'd2);
    repeat (4) step();
    check("ooo_drained", 64'(sb.size()), 64'd0);

    // Fill with write-back stalled, then wrap
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) issue(5'(8 + i), {32'hC0DE_0000, 32'(i)}, 5'(i + 1), 1'b1);
    for (int i = 0; i < 4; i++) respond(2'(i));
    bus.req_valid_i = 1'b1; bus.fpu_ready_i = 1'b1; bus.req_rd_i = 5'd12;
    bus.req_operands_i = {3{64'h1234_5678_9ABC_DEF0}};
    @(negedge clk);
    check("full_req_ready", 64'(bus.req_ready_o), 64'd0);
    check("full_fpu_valid", 64'(bus.fpu_valid_o), 64'd0);
    check("full_busy", 64'(bus.busy_o), 64'd1);
    step();
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    check("full_retire_no_reuse", 64'(bus.req_ready_o), 64'd0);
    step();
    @(negedge clk);
    check("wrap_accept", 64'(bus.req_ready_o), 64'd1);
    check("wrap_tag", 64'(bus.fpu_tag_o), 64'(tail_m));
    exp_res[tail_m] = 64'h1234_5678_9ABC_DEF0; exp_sts[tail_m] = 5'h02;
    e5.rd = 5'd12; e5.res = 64'h1234_5678_9ABC_DEF0; e5.sts = 5'h02;
    sb.push_back(e5);
    tail_m = (tail_m + 1) % 4;
    step();
    bus.req_valid_i = 1'b0;
    respond(2'd0);
    repeat (5) step();
    check("full_drained", 64'(sb.size()), 64'd0);

    // Flush with a completed head and a response in flight
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) issue(5'(17 + i), {32'hF1F1_0000, 32'(i)}, 5'd0, 1'b0);
    respond(2'd1);
    @(negedge clk);
    check("pre_flush_wb_valid", 64'(bus.wb_valid_o), 64'd1);
    step();
    bus.flush_i = 1'b1; bus.req_valid_i = 1'b1;
    bus.fpu_rsp_valid_i = 1'b1; bus.fpu_tag_i = 2'd2; bus.fpu_result_i = exp_res[2];
    @(negedge clk);
    check("flush_fpu_flush", 64'(bus.fpu_flush_o), 64'd1);
    check("flush_wb_forced_low", 64'(bus.wb_valid_o), 64'd0);
    check("flush_req_ready", 64'(bus.req_ready_o), 64'd0);
    check("flush_fpu_valid", 64'(bus.fpu_valid_o), 64'd0);
    step();
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0; bus.fpu_rsp_valid_i = 1'b0;
    tail_m = 0;
    @(negedge clk);
    check("post_flush_busy", 64'(bus.busy_o), 64'd0);
    check("post_flush_err", 64'(bus.err_o), 64'd0);
    check("post_flush_wb", 64'(bus.wb_valid_o), 64'd0);
    step();
    bus.wb_ready_i = 1'b1;
    issue(5'd21, 64'hBFF0_0000_0000_0000, 5'h08, 1'b1);
    respond(2'd0);
    repeat (3) step();
    check("flush_drained", 64'(sb.size()), 64'd0);

    // Response to a FREE tag is dropped and flagged until reset
    respond(2'd2);
    @(negedge clk);
    check("badtag_err", 64'(bus.err_o), 64'd1);
    check("badtag_busy", 64'(bus.busy_o), 64'd0);
    check("badtag_wb", 64'(bus.wb_valid_o), 64'd0);
    repeat (3) step();
    @(negedge clk);
    check("badtag_err_sticky", 64'(bus.err_o), 64'd1);
    step();
    rst_n = 1'b0;
    #2 check("rst_err_clear", 64'(bus.err_o), 64'd0);
    step();
    rst_n = 1'b1;
    tail_m = 0;

    // Reset while an op is in flight, then its late response
    issue(5'd9, 64'h0000_0000_0000_0009, 5'd0, 1'b0);
    @(negedge clk);
    check("midop_busy", 64'(bus.busy_o), 64'd1);
    step();
    rst_n = 1'b0;
    #2 check("midop_rst_busy", 64'(bus.busy_o), 64'd0);
    step();
    rst_n = 1'b1;
    tail_m = 0;
    respond(2'd0);
    @(negedge clk);
    check("late_rsp_err", 64'(bus.err_o), 64'd1);
    check("late_rsp_wb", 64'(bus.wb_valid_o), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpnew_issue_rob.md
Name: fpnew_issue_rob

Overview:
- Requester-side companion to the FPU top: accepts FP ops from the core, tags and issues them into the FPU's valid/ready request port, and collects tagged responses.
- Responses can return out of order because opgroups have different latencies and share a round-robin output arbiter. The block reorders them and retires in program order to the core's FP write-back port.
- Sits between the core's FP issue stage and the FPU top.

Parameters:
- Width, 64, operand/result width; must equal the FPU width.
- CtrlWidth, 16, opaque control bundle (rnd_mode, op, op_mod, fmts, vectorial) forwarded unchanged.
- NumEntries, 4, reorder-buffer depth; power of two, >= 2.
- RdWidth, 5, destination register address width.
- TagWidth, $clog2(NumEntries), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted
- req_operands_i  in  3*Width  operands
- req_ctrl_i  in  CtrlWidth  op control bundle
- req_rd_i  in  RdWidth  destination register
- fpu_valid_o  out  1  FPU request valid
- fpu_ready_i  in  1  FPU in_ready
- fpu_operands_o  out  3*Width  = req_operands_i
- fpu_ctrl_o  out  CtrlWidth  = req_ctrl_i
- fpu_tag_o  out  TagWidth  allocated entry index
- fpu_flush_o  out  1  = flush_i
- fpu_rsp_valid_i  in  1  FPU out_valid
- fpu_rsp_ready_o  out  1  FPU out_ready
- fpu_result_i  in  Width  FPU result
- fpu_status_i  in  5  FPU status {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TagWidth  returned tag
- wb_valid_o  out  1  in-order result valid
- wb_ready_i  in  1  core write-back ready
- wb_result_o  out  Width  result
- wb_status_o  out  5  fflags
- wb_rd_o  out  RdWidth  destination register
- flush_i  in  1  drop everything in flight
- busy_o  out  1  any entry not FREE
- err_o  out  1  sticky: response tag hit a non-ISSUED entry

Behaviour:
- Storage: NumEntries entries of {state, rd, result, status}. Entry states: FREE -> ISSUED -> DONE -> FREE.
- Pointers: head (retire) and tail (allocate), each TagWidth bits, wrapping modulo NumEntries. count has TagWidth+1 bits; full when count==NumEntries.
- Issue:
  - fpu_valid_o = req_valid_i & ~full & ~flush_i.
  - req_ready_o = fpu_ready_i & ~full & ~flush_i.
  - fpu_tag_o = tail.
  - On req_valid_i & req_ready_o: entry[tail] becomes ISSUED with rd captured, and tail increments.
  - Issue path is combinational, with no added latency. A core request is never accepted unless the FPU accepts it in the same cycle.
- Response:
  - fpu_rsp_ready_o = 1 always, since space is reserved at issue.
  - On fpu_rsp_valid_i with entry[fpu_tag_i] ISSUED: store result and status; state becomes DONE.
  - If the target entry is not ISSUED: the response is dropped and err_o is set (sticky until reset).
- Retire:
  - wb_valid_o = entry[head] is DONE. wb_* fields come from entry[head].
  - On wb_valid_o & wb_ready_i: entry becomes FREE and head increments.
  - Latency from FPU response to wb_valid_o is 1 cycle (registered).
- Simultaneous events:
  - Allocate and retire in the same cycle: count unchanged.
  - When full, allocation is blocked even if a retire happens that cycle (no same-cycle reuse).
  - A response for entry X and a retire of a different entry in the same cycle are both honoured.
- Flush:
  - When flush_i=1: all entries become FREE, head, tail and count go to 0, and responses arriving that cycle are ignored (err_o not set).
  - fpu_flush_o follows flush_i combinationally.
  - wb_valid_o is forced low during the flush cycle.
- Reset (async): all entries FREE, pointers and count 0, err_o 0. Resulting output values: wb_valid_o=0, busy_o=0, req_ready_o=0 unless fpu_ready_i, and wb data outputs 0.
- Reset asserted mid-operation discards all in-flight ops; responses after reset deassertion to FREE tags set err_o.
- busy_o = count!=0.

Optional Feature:
- Macro: FPNEW_ISSUE_ROB_BYPASS_EN.
- Defined: when entry[head] is ISSUED and fpu_rsp_valid_i with fpu_tag_i==head, wb_valid_o asserts combinationally that cycle with fpu_result_i, fpu_status_i and the stored rd.
  - If wb_ready_i: the entry goes straight to FREE and head increments.
  - Otherwise: the entry stores the response as DONE.
  - Zero-cycle latency for in-order returns.
- Undefined: no bypass; latency is always 1 cycle.

Test Plan:
- Single op: issue rd=3 with fpu_ready_i=1; respond tag 0, result 0x4000_0000_0000_0000, status 0 next cycle -> wb_valid_o one cycle later, wb_rd_o=3, exact result; busy_o returns to 0.
- Out-of-order: issue tags 0,1,2 (rd 1,2,3); respond 2, then 0, then 1 -> write-backs in order rd 1,2,3 with matching results; rd 3 not presented before rd 2.
- Full/back-pressure: issue 4 ops with wb_ready_i=0 and all responded -> req_ready_o=0 on the 5th request even with fpu_ready_i=1. Raise wb_ready_i -> one retire per cycle; 5th issue accepted the cycle after the first retire, with tag 0 after wrap.
- Flush: 3 ops in flight, flush_i pulse while the response for tag 1 is valid -> fpu_flush_o=1, busy_o=0 next cycle, no write-back, err_o=0. Next request gets tag 0.
- Bad tag: response tag 2 with no ops outstanding -> dropped, err_o=1 and stays 1 until rst_ni low.
- Bypass (with FPNEW_ISSUE_ROB_BYPASS_EN): response for head tag with wb_ready_i=1 -> wb_valid_o in the same cycle. Without the macro -> one cycle later.
